// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions: widths, active-low levels, owner encoding and the per-master command bundle.
// Pure declarations, no timing; imported by the arbiter and its mux.
package bus_arbiter_pkg;

   localparam int BUS_ADDR_W  = 30;
   localparam int BUS_DATA_W  = 32;
   localparam int NUM_MASTERS = 4;

   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   typedef enum logic [1:0] {
      BUS_OWNER_MASTER_0 = 2'd0,
      BUS_OWNER_MASTER_1 = 2'd1,
      BUS_OWNER_MASTER_2 = 2'd2,
      BUS_OWNER_MASTER_3 = 2'd3
   } bus_owner_t;

   typedef struct packed {
      logic [BUS_ADDR_W-1:0] addr;
      logic                  as_;
      logic                  rw;
      logic [BUS_DATA_W-1:0] wr_dat;
   } bus_cmd_t;

   function automatic logic grant_level(input bus_owner_t owner, input bus_owner_t n);
      return (owner == n) ? ENABLE_ : DISABLE_;
   endfunction

endpackage

// File: rtl/bus_master_mux.sv
// Selects the owning master's address/strobe/direction/write-data onto the shared bus.
// Combinational, zero latency; no flow control, non-owners are ignored.
module bus_master_mux
   import bus_arbiter_pkg::*;
(
   input  bus_owner_t owner_i,
   input  bus_cmd_t   m0_cmd_i,
   input  bus_cmd_t   m1_cmd_i,
   input  bus_cmd_t   m2_cmd_i,
   input  bus_cmd_t   m3_cmd_i,
   output bus_cmd_t   bus_cmd_o
);

   always_comb begin
      bus_cmd_o = m0_cmd_i;
      case (owner_i)
         BUS_OWNER_MASTER_0: bus_cmd_o = m0_cmd_i;
         BUS_OWNER_MASTER_1: bus_cmd_o = m1_cmd_i;
         BUS_OWNER_MASTER_2: bus_cmd_o = m2_cmd_i;
         BUS_OWNER_MASTER_3: bus_cmd_o = m3_cmd_i;
         default:            bus_cmd_o = m0_cmd_i;
      endcase
   end

endmodule

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with parking and no pre-emption; grants decode a 2-bit owner register.
// Handover one cycle after the owner drops Req_; a holding owner blocks all others indefinitely.
module bus_arbiter
   import bus_arbiter_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_,

   input  logic                  M0BusReq_,
   input  logic                  M1BusReq_,
   input  logic                  M2BusReq_,
   input  logic                  M3BusReq_,

   output logic                  M0BusGrnt_,
   output logic                  M1BusGrnt_,
   output logic                  M2BusGrnt_,
   output logic                  M3BusGrnt_,

   input  logic [BUS_ADDR_W-1:0] M0BusAddr,
   input  logic [BUS_ADDR_W-1:0] M1BusAddr,
   input  logic [BUS_ADDR_W-1:0] M2BusAddr,
   input  logic [BUS_ADDR_W-1:0] M3BusAddr,

   input  logic                  M0BusAs_,
   input  logic                  M1BusAs_,
   input  logic                  M2BusAs_,
   input  logic                  M3BusAs_,

   input  logic                  M0BusRW,
   input  logic                  M1BusRW,
   input  logic                  M2BusRW,
   input  logic                  M3BusRW,

   input  logic [BUS_DATA_W-1:0] M0BusWrData,
   input  logic [BUS_DATA_W-1:0] M1BusWrData,
   input  logic [BUS_DATA_W-1:0] M2BusWrData,
   input  logic [BUS_DATA_W-1:0] M3BusWrData,

   output logic [BUS_ADDR_W-1:0] BusAddr,
   output logic                  BusAs_,
   output logic                  BusRW,
   output logic [BUS_DATA_W-1:0] BusWrData
);

   bus_owner_t                   owner_q;
   bus_owner_t                   owner_d;
   logic [NUM_MASTERS-1:0]       req_n;
   bus_cmd_t                     bus_cmd;

   assign req_n = {M3BusReq_, M2BusReq_, M1BusReq_, M0BusReq_};

   // Scan from farthest to nearest so the nearest requester (Owner+1) wins.
   always_comb begin
      logic [1:0] idx;
      owner_d = owner_q;
      idx     = owner_q;
      if (req_n[owner_q] == DISABLE_) begin
         for (int k = 3; k >= 1; k--) begin
            idx = owner_q + 2'(k);
            if (req_n[idx] == ENABLE_) begin
               owner_d = bus_owner_t'(idx);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         owner_q <= BUS_OWNER_MASTER_0;
      end else begin
         owner_q <= owner_d;
      end
   end

   assign M0BusGrnt_ = grant_level(owner_q, BUS_OWNER_MASTER_0);
   assign M1BusGrnt_ = grant_level(owner_q, BUS_OWNER_MASTER_1);
   assign M2BusGrnt_ = grant_level(owner_q, BUS_OWNER_MASTER_2);
   assign M3BusGrnt_ = grant_level(owner_q, BUS_OWNER_MASTER_3);

   bus_master_mux u_mux (
      .owner_i   (owner_q),
      .m0_cmd_i  ('{addr: M0BusAddr, as_: M0BusAs_, rw: M0BusRW, wr_dat: M0BusWrData}),
      .m1_cmd_i  ('{addr: M1BusAddr, as_: M1BusAs_, rw: M1BusRW, wr_dat: M1BusWrData}),
      .m2_cmd_i  ('{addr: M2BusAddr, as_: M2BusAs_, rw: M2BusRW, wr_dat: M2BusWrData}),
      .m3_cmd_i  ('{addr: M3BusAddr, as_: M3BusAs_, rw: M3BusRW, wr_dat: M3BusWrData}),
      .bus_cmd_o (bus_cmd)
   );

   assign BusAddr   = bus_cmd.addr;
   assign BusAs_    = bus_cmd.as_;
   assign BusRW     = bus_cmd.rw;
   assign BusWrData = bus_cmd.wr_dat;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, round-robin handover, no pre-emption, mux select, async reset, back-to-back tenures.
module tb_bus_arbiter;

   logic        clk;
   logic        reset_;
   logic [3:0]  req_n;
   wire  [3:0]  grnt_n;
   logic [29:0] m_addr [4];
   logic        m_as_n [4];
   logic        m_rw   [4];
   logic [31:0] m_wdat [4];
   wire  [29:0] bus_addr;
   wire         bus_as_n;
   wire         bus_rw;
   wire  [31:0] bus_wdat;

   int total = 0;
   int bad   = 0;

   bus_arbiter dut (
      .clk         (clk),
      .reset_      (reset_),
      .M0BusReq_   (req_n[0]),
      .M1BusReq_   (req_n[1]),
      .M2BusReq_   (req_n[2]),
      .M3BusReq_   (req_n[3]),
      .M0BusGrnt_  (grnt_n[0]),
      .M1BusGrnt_  (grnt_n[1]),
      .M2BusGrnt_  (grnt_n[2]),
      .M3BusGrnt_  (grnt_n[3]),
      .M0BusAddr   (m_addr[0]),
      .M1BusAddr   (m_addr[1]),
      .M2BusAddr   (m_addr[2]),
      .M3BusAddr   (m_addr[3]),
      .M0BusAs_    (m_as_n[0]),
      .M1BusAs_    (m_as_n[1]),
      .M2BusAs_    (m_as_n[2]),
      .M3BusAs_    (m_as_n[3]),
      .M0BusRW     (m_rw[0]),
      .M1BusRW     (m_rw[1]),
      .M2BusRW     (m_rw[2]),
      .M3BusRW     (m_rw[3]),
      .M0BusWrData (m_wdat[0]),
      .M1BusWrData (m_wdat[1]),
      .M2BusWrData (m_wdat[2]),
      .M3BusWrData (m_wdat[3]),
      .BusAddr     (bus_addr),
      .BusAs_      (bus_as_n),
      .BusRW       (bus_rw),
      .BusWrData   (bus_wdat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Exactly one grant low on every cycle, including across reset.
   always @(negedge clk) begin
      total++;
      if ($countones(~grnt_n) !== 1) begin
         bad++;
         $display("FAIL onehot_grant: grants=%b required exactly one low", grnt_n);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_ = 1'b0;
      req_n  = 4'b1111;
      #2;
      total++;
      if (grnt_n !== 4'b1110) begin
         bad++; $display("FAIL reset_grant: got=%b exp=1110", grnt_n);
      end
      total++;
      if (bus_addr !== 30'h0AAA_0000) begin
         bad++; $display("FAIL reset_mux_addr: got=%h exp=0aaa0000", bus_addr);
      end
      tick();
      @(negedge clk);
      reset_ = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         total++;
         if (grnt_n !== 4'b1110 || bus_addr !== 30'h0AAA_0000) begin
            bad++; $display("FAIL reset_park cyc=%0d: grant=%b addr=%h exp grant=1110 addr=0aaa0000", i, grnt_n, bus_addr);
         end
      end
   endtask

   task automatic test_handover();
      req_n = 4'b0100;
      tick();
      total++;
      if (grnt_n !== 4'b1110) begin
         bad++; $display("FAIL handover_hold0: got=%b exp=1110", grnt_n);
      end
      req_n = 4'b0101;
      tick();
      total++;
      if (grnt_n !== 4'b1101) begin
         bad++; $display("FAIL handover_to1: got=%b exp=1101", grnt_n);
      end
      req_n = 4'b0111;
      tick();
      total++;
      if (grnt_n !== 4'b0111) begin
         bad++; $display("FAIL handover_to3: got=%b exp=0111", grnt_n);
      end
      req_n = 4'b1110;
      tick();
      total++;
      if (grnt_n !== 4'b1110) begin
         bad++; $display("FAIL handover_wrap0: got=%b exp=1110", grnt_n);
      end
      req_n = 4'b1111;
      tick();
      total++;
      if (grnt_n !== 4'b1110) begin
         bad++; $display("FAIL handover_park0: got=%b exp=1110", grnt_n);
      end
   endtask

   task automatic test_no_preempt();
      req_n = 4'b1011;
      tick();
      total++;
      if (grnt_n !== 4'b1011) begin
         bad++; $display("FAIL preempt_get2: got=%b exp=1011", grnt_n);
      end
      req_n = 4'b0000;
      for (int i = 0; i < 20; i++) begin
         tick();
         total++;
         if (grnt_n !== 4'b1011) begin
            bad++; $display("FAIL preempt_hold cyc=%0d: got=%b exp=1011", i, grnt_n);
         end
      end
      req_n = 4'b0100;
      tick();
      total++;
      if (grnt_n !== 4'b0111) begin
         bad++; $display("FAIL preempt_next3: got=%b exp=0111", grnt_n);
      end
      req_n = 4'b1111;
      tick();
      total++;
      if (grnt_n !== 4'b0111) begin
         bad++; $display("FAIL preempt_park3: got=%b exp=0111", grnt_n);
      end
   endtask

   task automatic test_mux();
      req_n = 4'b1101;
      tick();
      total++;
      if (grnt_n !== 4'b1101) begin
         bad++; $display("FAIL mux_get1: got=%b exp=1101", grnt_n);
      end
      m_addr[1] = 30'h0000_1234; m_as_n[1] = 1'b0; m_rw[1] = 1'b0; m_wdat[1] = 32'hDEAD_BEEF;
      m_addr[2] = 30'h3FFF_0000; m_as_n[2] = 1'b0; m_rw[2] = 1'b1; m_wdat[2] = 32'h1234_5678;
      #1;
      total++;
      if (bus_addr !== 30'h0000_1234 || bus_as_n !== 1'b0 || bus_rw !== 1'b0 || bus_wdat !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL mux_m1: got addr=%h as=%b rw=%b wd=%h exp 00001234/0/0/deadbeef", bus_addr, bus_as_n, bus_rw, bus_wdat);
      end
      m_addr[2] = 30'h2222_2222; m_wdat[2] = 32'h0BAD_F00D; m_as_n[0] = 1'b0; m_rw[3] = 1'b0;
      #1;
      total++;
      if (bus_addr !== 30'h0000_1234 || bus_as_n !== 1'b0 || bus_rw !== 1'b0 || bus_wdat !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL mux_nonowner: got addr=%h as=%b rw=%b wd=%h exp 00001234/0/0/deadbeef", bus_addr, bus_as_n, bus_rw, bus_wdat);
      end
      req_n = 4'b1011;
      tick();
      total++;
      if (grnt_n !== 4'b1011 || bus_addr !== 30'h2222_2222 || bus_rw !== 1'b1 || bus_wdat !== 32'h0BAD_F00D) begin
         bad++; $display("FAIL mux_m2: grant=%b addr=%h rw=%b wd=%h exp 1011/22222222/1/0badf00d", grnt_n, bus_addr, bus_rw, bus_wdat);
      end
   endtask

   task automatic test_async_reset();
      req_n = 4'b0111;
      tick();
      total++;
      if (grnt_n !== 4'b0111) begin
         bad++; $display("FAIL areset_get3: got=%b exp=0111", grnt_n);
      end
      @(negedge clk);
      reset_ = 1'b0;
      req_n  = 4'b1011;
      #1;
      total++;
      if (grnt_n !== 4'b1110 || bus_addr !== 30'h0AAA_0000) begin
         bad++; $display("FAIL areset_immediate: grant=%b addr=%h exp 1110/0aaa0000", grnt_n, bus_addr);
      end
      tick();
      @(negedge clk);
      reset_ = 1'b1;
      #1;
      total++;
      if (grnt_n !== 4'b1110) begin
         bad++; $display("FAIL areset_release: got=%b exp=1110", grnt_n);
      end
      tick();
      total++;
      if (grnt_n !== 4'b1011) begin
         bad++; $display("FAIL areset_then2: got=%b exp=1011", grnt_n);
      end
   endtask

   task automatic test_back_to_back();
      int exp_own [10];
      logic [3:0] exp_g;
      exp_own = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
      req_n = 4'b1110;
      tick();
      for (int i = 0; i < 10; i++) begin
         exp_g = 4'b1111;
         exp_g[exp_own[i]] = 1'b0;
         total++;
         if (grnt_n !== exp_g) begin
            bad++; $display("FAIL b2b step=%0d: got=%b exp=%b", i, grnt_n, exp_g);
         end
         req_n = 4'b0000;
         if (i % 2 == 1) req_n[exp_own[i]] = 1'b1;
         tick();
      end
      req_n = 4'b1111;
   endtask

   initial begin
      reset_ = 1'b0;
      req_n  = 4'b1111;
      m_addr = '{30'h0AAA_0000, 30'h0111_1111, 30'h0222_2222, 30'h0333_3333};
      m_as_n = '{1'b1, 1'b1, 1'b1, 1'b1};
      m_rw   = '{1'b1, 1'b1, 1'b1, 1'b1};
      m_wdat = '{32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hC2C2_C2C2, 32'hD3D3_D3D3};
      test_reset();
      test_handover();
      test_no_preempt();
      test_mux();
      test_async_reset();
      test_back_to_back();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
